// File: rtl/fmul_iter.sv
// fmul_iter: sequential floating-point multiplier with a shift-add mantissa
// datapath, round-to-nearest-even, flush-to-zero and exception flags.
module fmul_iter #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;          // significand width with hidden bit
    localparam int PW = 2 * SW;             // full product width
    localparam int EW = EXP_W + 2;          // signed working exponent width
    localparam int CW = $clog2(SW);
    localparam logic [CW-1:0]        CNT_LAST = CW'(MAN_W);
    localparam logic signed [EW-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] EXP_INF  = {2'b00, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                 state, state_nx;
    logic [PW-1:0]          mcand;
    logic [SW-1:0]          mplier;
    logic [PW-1:0]          acc;
    logic signed [EW-1:0]   exp_r;
    logic [CW-1:0]          cnt;
    logic                   sgn_r;
    logic                   spec_r;

    // operand fields and classification
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, sgn;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_fl;

    assign ea     = a[W-2 -: EXP_W];
    assign eb     = b[W-2 -: EXP_W];
    assign fa     = a[MAN_W-1:0];
    assign fb     = b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign sgn    = a[W-1] ^ b[W-1];

    // special-value result selection
    always_comb begin
        spec_res = {sgn, {(W-1){1'b0}}};
        spec_fl  = 4'b0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_fl  = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // normalisation and rounding of the finished product
    logic [PW-2:0]        norm;
    logic [MAN_W-1:0]     frac, frac_rnd;
    logic                 guard, sticky, round_up, carry;
    logic signed [EW-1:0] exp_n;
    logic                 ovf, unf;

    always_comb begin
        norm     = acc[PW-1] ? acc[PW-2:0] : {acc[PW-3:0], 1'b0};
        frac     = norm[PW-2 -: MAN_W];
        guard    = norm[PW-2-MAN_W];
        sticky   = |norm[PW-3-MAN_W:0];
        round_up = guard & (sticky | frac[0]);
        {carry, frac_rnd} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        exp_n    = exp_r + {{(EW-1){1'b0}}, acc[PW-1]} + {{(EW-1){1'b0}}, carry};
        ovf      = !exp_n[EW-1] && (exp_n >= EXP_INF);
        unf      = exp_n[EW-1] || (exp_n == '0);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state and handshake outputs
    // specials pass through NORM so their result appears one edge after accept
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = special ? NORM : MUL;
            end
            MUL:  if (cnt == CNT_LAST) state_nx = NORM;
            NORM: state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // operand load, shift-add iteration and result formatting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            exp_r  <= '0;
            cnt    <= '0;
            sgn_r  <= 1'b0;
            spec_r <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sgn_r  <= sgn;
                    spec_r <= special;
                    mcand  <= {{SW{1'b0}}, 1'b1, fa};
                    mplier <= {1'b1, fb};
                    acc    <= '0;
                    cnt    <= '0;
                    exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    if (special) begin
                        result <= spec_res;
                        flags  <= spec_fl;
                    end
                end
                MUL: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                NORM: if (!spec_r) begin
                    if (ovf) begin
                        result <= {sgn_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags  <= 4'b0101;
                    end else if (unf) begin
                        result <= {sgn_r, {(W-1){1'b0}}};
                        flags  <= 4'b0011;
                    end else begin
                        result <= {sgn_r, exp_n[EXP_W-1:0], frac_rnd};
                        flags  <= {3'b000, guard | sticky};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_iter.sv
// Bench for fmul_iter: directed operations at half and single precision,
// expectations queued at issue and compared when the result is presented.
module tb_fmul_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, res16;
    logic [3:0]  fl16;
    logic        iv32, ir32, ov32, or32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  fl32;

    int total = 0;
    int bad   = 0;
    logic [35:0] sb[$];

    always #5 clk = ~clk;

    fmul_iter u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
        .result(res16), .flags(fl16)
    );

    fmul_iter #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32),
        .result(res32), .flags(fl32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // issue one operation, measure latency, compare against the queued expectation
    task automatic run_op(input bit wide, input logic [31:0] oa, input logic [31:0] ob,
                          input logic [31:0] er, input logic [3:0] ef,
                          input int lat, input string tag);
        int n;
        logic [35:0] e;
        logic [31:0] got_r;
        logic [3:0]  got_f;
        sb.push_back({er, ef});
        if (wide) begin a32 = oa; b32 = ob; iv32 = 1'b1; end
        else begin a16 = oa[15:0]; b16 = ob[15:0]; iv16 = 1'b1; end
        @(posedge clk); #1;
        iv16 = 1'b0; iv32 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        a32 = $urandom; b32 = $urandom;
        n = 0;
        while (!(wide ? ov32 : ov16) && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_lat"}, n, lat);
        e = sb.pop_front();
        got_r = wide ? res32 : {16'h0, res16};
        got_f = wide ? fl32 : fl16;
        check({tag, "_res"}, got_r, e[35:4]);
        check({tag, "_flags"}, {28'h0, got_f}, {28'h0, e[3:0]});
        if (wide) or32 = 1'b1; else or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0; or32 = 1'b0;
        check({tag, "_rdy"}, {31'h0, wide ? ir32 : ir16}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] x;
        int hits;
        rst_n = 1'b0;
        iv16 = 0; or16 = 0; a16 = '0; b16 = '0;
        iv32 = 0; or32 = 0; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, ir16}, 32'h1);
        check("rst_out_valid", {31'h0, ov16}, 32'h0);
        check("rst_result", {16'h0, res16}, 32'h0);
        check("rst_flags", {28'h0, fl16}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 32'h3E00, 32'h4000, 32'h4200, 4'b0000, 12, "basic");
        run_op(0, 32'hBE00, 32'h3E00, 32'hC080, 4'b0000, 12, "neg");
        run_op(0, 32'h3C01, 32'h3C01, 32'h3C02, 4'b0001, 12, "round");
        for (int i = 0; i < 4; i++) begin
            x[15]    = 1'($urandom_range(0, 1));
            x[14:10] = 5'($urandom_range(1, 30));
            x[9:0]   = 10'($urandom);
            run_op(0, 32'h3C00, {16'h0, x}, {16'h0, x}, 4'b0000, 12, "ident");
        end
        run_op(0, 32'h7BFF, 32'h4000, 32'h7C00, 4'b0101, 12, "ovf");
        run_op(0, 32'hFBFF, 32'h4000, 32'hFC00, 4'b0101, 12, "ovf_neg");
        run_op(0, 32'h0400, 32'h3800, 32'h0000, 4'b0011, 12, "unf");
        run_op(0, 32'h0001, 32'h3C00, 32'h0000, 4'b0000, 1, "subn");
        run_op(0, 32'h7C00, 32'h0000, 32'h7E00, 4'b1000, 1, "inf_zero");
        run_op(0, 32'h7E01, 32'h3C00, 32'h7E00, 4'b1000, 1, "nan");
        run_op(0, 32'hFC00, 32'h4000, 32'hFC00, 4'b0000, 1, "inf_fin");
        run_op(0, 32'h7C00, 32'hFC00, 32'hFC00, 4'b0000, 1, "inf_inf");

        // result held while the consumer stalls; in_valid in DONE is ignored
        a16 = 16'h3E00; b16 = 16'h4000; iv16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'h7C00; b16 = 16'h0000;
        hits = 0;
        while (!ov16 && hits < 60) begin @(posedge clk); #1; hits++; end
        check("hold_lat", hits, 12);
        for (int i = 0; i < 5; i++) begin
            check("hold_res", {16'h0, res16}, 32'h4200);
            check("hold_in_ready", {31'h0, ir16}, 32'h0);
            @(posedge clk); #1;
        end
        iv16 = 1'b0;
        check("hold_valid", {31'h0, ov16}, 32'h1);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check("hold_release", {30'h0, ov16, ir16}, 32'h1);

        // reset during MUL aborts the operation
        a16 = 16'h3E00; b16 = 16'h3E00; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'h0, ov16}, 32'h0);
        check("abort_in_ready", {31'h0, ir16}, 32'h1);
        check("abort_result", {16'h0, res16}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov16) hits++;
        end
        check("abort_no_stale", hits, 0);
        run_op(0, 32'h3E00, 32'h3E00, 32'h4080, 4'b0000, 12, "after_abort");

        run_op(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 25, "sp_basic");
        run_op(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, "sp_inf_zero");
        run_op(1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 25, "sp_ovf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
